eeg_pea_out_collector: RTL and testbench
========================================

Name: eeg_pea_out_collector

Overview:
- Receiving end of the PE-array output stream interface (per-PE VLD/LST/RDY/DAT/ADD).
- Round-robin arbitrates PE_NUM output streams into one ORAM write port through a single registered stage.
- Tracks the per-PE last beat and pulses DONE once every PE has delivered LST and the write stage has drained.
- Sits between the PE array engine and the output RAM mux.

Parameters:
- PE_NUM, 16: number of PE output streams (PE_COL*PE_ROW, flattened column-major, index = col*PE_ROW+row).
- DATA_OUT_DW, 8: output data width.
- OMUX_ADD_AW, 8: per-PE output address width.
- ORAM_ADD_AW, 10: ORAM address width.
- PE_IDX_AW, 4: width of the PE index, equal to $clog2(PE_NUM).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- CFG_START  in  1  one-cycle start pulse; honoured only in IDLE.
- CFG_OUT_BASE  in  ORAM_ADD_AW  base address; latched on an accepted CFG_START.
- IS_IDLE  out  1  high in IDLE.
- DONE  out  1  one-cycle pulse when the layer is complete.
- OUT_VLD  in  PE_NUM  per-PE output valid.
- OUT_LST  in  PE_NUM  per-PE last beat.
- OUT_RDY  out  PE_NUM  per-PE ready (one-hot or zero).
- OUT_DAT  in  PE_NUM*DATA_OUT_DW  per-PE data.
- OUT_ADD  in  PE_NUM*OMUX_ADD_AW  per-PE local address.
- ORAM_VLD  out  1  write request valid.
- ORAM_RDY  in  1  RAM accepts the write.
- ORAM_ADD  out  ORAM_ADD_AW  write address.
- ORAM_BNK  out  PE_IDX_AW  source PE index (bank select).
- ORAM_DAT  out  DATA_OUT_DW  write data.

Behaviour:
- Reset: state=IDLE, IS_IDLE=1, DONE=0, ORAM_VLD=0, ORAM_ADD/BNK/DAT=0, lst_seen=0, rr_ptr=0. OUT_RDY=0 while in IDLE.
- FSM has three states: IDLE, RUN, FIN.
  - IDLE: on CFG_START, latch base, clear lst_seen, go to RUN.
  - RUN: arbitrate streams. When lst_seen is all ones and ORAM_VLD=0 (or draining this cycle), go to FIN.
  - FIN: DONE=1 for exactly one cycle, then go to IDLE.
- CFG_START in RUN or FIN is ignored.
- Eligible requests: req[i] = OUT_VLD[i] & ~lst_seen[i]. A PE that has delivered LST gets RDY=0 until the next CFG_START.
- Stage free: stg_free = ~ORAM_VLD | ORAM_RDY.
- Grant:
  - Only in RUN with stg_free=1.
  - Goes to the first eligible i searching rr_ptr, rr_ptr+1, … modulo PE_NUM.
  - OUT_RDY = grant, which is combinational from OUT_VLD, ORAM_RDY and state.
  - After a grant to i, rr_ptr <= (i+1) mod PE_NUM. rr_ptr is unchanged when there is no grant.
- Accepted beat (OUT_VLD[i] & OUT_RDY[i]):
  - Next cycle: ORAM_VLD=1, ORAM_DAT=OUT_DAT[i], ORAM_BNK=i, ORAM_ADD=(base + zero-extended OUT_ADD[i]) mod 2^ORAM_ADD_AW. Latency is 1 cycle.
  - If OUT_LST[i]=1, lst_seen[i] is set in the same cycle.
- ORAM stage holds:
  - ORAM_VLD stays high with stable ADD/BNK/DAT until ORAM_RDY=1.
  - Same-cycle drain and refill is allowed, giving one beat/cycle throughput with ORAM_RDY tied high.
  - If drained with no new grant, ORAM_VLD <= 0.
- Simultaneous LST from several PEs: one is granted per cycle; the others wait.
- DONE requires the last LST beat to have been written, i.e. ORAM_VLD=0 or ORAM_RDY=1 in the RUN→FIN cycle.
- OUT_VLD in IDLE/FIN is not acknowledged; no write occurs.
- rst asserted mid-RUN: everything returns to reset values next cycle. Any pending ORAM beat is dropped; no DONE pulse.
- Address overflow wraps silently.

Test Plan:
- Single PE: base=0x100, PE 5 sends 3 beats ADD=0,1,2 with DAT=0x11,0x22,0x33, LST on the 3rd; the other 15 PEs send one LST beat each.
  → Writes land at 0x100..0x102 with BNK=5. DONE pulses exactly once, 1 cycle after the final write is accepted. IS_IDLE returns to 1.
- All 16 PEs hold VLD continuously with ORAM_RDY=1.
  → Grants rotate 0,1,…,15,0 with one write per cycle. No PE is granted twice before the others.
- ORAM_RDY held low for 4 cycles with ORAM_VLD=1.
  → ORAM_ADD/DAT/BNK stay stable and OUT_RDY is all 0. On ORAM_RDY=1, the next grant occurs that same cycle.
- Wrap: base=0x3F0 with OUT_ADD=0x20 → ORAM_ADD=0x010.
- PE 3 sends LST, then keeps VLD high.
  → OUT_RDY[3] stays 0. Remaining PEs finish, DONE asserts, and PE 3's extra beat is never written.
- rst pulsed while 2 beats are pending.
  → Next cycle ORAM_VLD=0, IS_IDLE=1, no DONE. A fresh CFG_START runs normally.

Source files
------------

// File: rtl/eeg_pea_out_collector.sv
// eeg_pea_out_collector: round-robin collector from PE output streams into the ORAM write port.
// One registered write stage; DONE pulses once every PE has sent its last beat and the stage drained.
module eeg_pea_out_collector #(
    parameter int unsigned PE_NUM      = 16,
    parameter int unsigned DATA_OUT_DW = 8,
    parameter int unsigned OMUX_ADD_AW = 8,
    parameter int unsigned ORAM_ADD_AW = 10,
    parameter int unsigned PE_IDX_AW   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          CFG_START,
    input  logic [ORAM_ADD_AW-1:0]        CFG_OUT_BASE,
    output logic                          IS_IDLE,
    output logic                          DONE,
    input  logic [PE_NUM-1:0]             OUT_VLD,
    input  logic [PE_NUM-1:0]             OUT_LST,
    output logic [PE_NUM-1:0]             OUT_RDY,
    input  logic [PE_NUM*DATA_OUT_DW-1:0] OUT_DAT,
    input  logic [PE_NUM*OMUX_ADD_AW-1:0] OUT_ADD,
    output logic                          ORAM_VLD,
    input  logic                          ORAM_RDY,
    output logic [ORAM_ADD_AW-1:0]        ORAM_ADD,
    output logic [PE_IDX_AW-1:0]          ORAM_BNK,
    output logic [DATA_OUT_DW-1:0]        ORAM_DAT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     st_idle_c, st_run_c, st_fin_c;

    logic [ORAM_ADD_AW-1:0]   base_q, base_d;
    logic [PE_NUM-1:0]        lst_seen_q, lst_seen_d;
    logic [PE_IDX_AW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                     oram_vld_q, oram_vld_d;
    logic [ORAM_ADD_AW-1:0]   oram_add_q, oram_add_d;
    logic [PE_IDX_AW-1:0]     oram_bnk_q, oram_bnk_d;
    logic [DATA_OUT_DW-1:0]   oram_dat_q, oram_dat_d;

    logic                     stg_free_c;
    logic                     lst_all_c;
    logic [PE_NUM-1:0]        req_c;
    logic                     gnt_vld_c;
    logic [PE_IDX_AW-1:0]     gnt_idx_c;
    logic [PE_IDX_AW-1:0]     gnt_nxt_c;
    logic [DATA_OUT_DW-1:0]   gnt_dat_c;
    logic [OMUX_ADD_AW-1:0]   gnt_add_c;
    logic                     gnt_lst_c;
    logic [31:0]              best_dist_c;
    logic [31:0]              dist_c;

    assign stg_free_c = ~oram_vld_q | ORAM_RDY;
    assign lst_all_c  = &lst_seen_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start from IDLE, finish once all LSTs seen and the stage is drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (CFG_START) state_d = ST_RUN;
            ST_RUN:  if (lst_all_c && stg_free_c) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State decode outputs
    always_comb begin
        st_idle_c = 1'b0;
        st_run_c  = 1'b0;
        st_fin_c  = 1'b0;
        case (state_q)
            ST_IDLE: st_idle_c = 1'b1;
            ST_RUN:  st_run_c  = 1'b1;
            ST_FIN:  st_fin_c  = 1'b1;
            default: st_idle_c = 1'b0;
        endcase
        IS_IDLE = st_idle_c;
        DONE    = st_fin_c;
    end

    // Round-robin arbiter: pick the eligible PE closest to rr_ptr (modular distance)
    always_comb begin
        req_c       = OUT_VLD & ~lst_seen_q;
        best_dist_c = 32'(PE_NUM);
        dist_c      = '0;
        gnt_idx_c   = '0;
        gnt_dat_c   = '0;
        gnt_add_c   = '0;
        gnt_lst_c   = 1'b0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            dist_c = 32'(i) + 32'(PE_NUM) - 32'(rr_ptr_q);
            if (dist_c >= 32'(PE_NUM)) dist_c = dist_c - 32'(PE_NUM);
            if (req_c[i] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                gnt_idx_c   = PE_IDX_AW'(i);
                gnt_dat_c   = OUT_DAT[i*DATA_OUT_DW +: DATA_OUT_DW];
                gnt_add_c   = OUT_ADD[i*OMUX_ADD_AW +: OMUX_ADD_AW];
                gnt_lst_c   = OUT_LST[i];
            end
        end
        gnt_vld_c = st_run_c & stg_free_c & (best_dist_c < 32'(PE_NUM));
        gnt_nxt_c = (32'(gnt_idx_c) == 32'(PE_NUM) - 32'd1) ? '0 : gnt_idx_c + PE_IDX_AW'(1);
        OUT_RDY   = gnt_vld_c ? (PE_NUM'(1) << gnt_idx_c) : '0;
    end

    // Datapath next-state: config latch, LST tracking, write stage load/drain
    always_comb begin
        base_d     = base_q;
        lst_seen_d = lst_seen_q;
        rr_ptr_d   = rr_ptr_q;
        oram_vld_d = oram_vld_q;
        oram_add_d = oram_add_q;
        oram_bnk_d = oram_bnk_q;
        oram_dat_d = oram_dat_q;
        if (st_idle_c && CFG_START) begin
            base_d     = CFG_OUT_BASE;
            lst_seen_d = '0;
        end
        if (gnt_vld_c) begin
            oram_vld_d = 1'b1;
            oram_add_d = base_q + ORAM_ADD_AW'(gnt_add_c);
            oram_bnk_d = gnt_idx_c;
            oram_dat_d = gnt_dat_c;
            rr_ptr_d   = gnt_nxt_c;
            if (gnt_lst_c) lst_seen_d[gnt_idx_c] = 1'b1;
        end else if (ORAM_RDY) begin
            oram_vld_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            lst_seen_q <= '0;
            rr_ptr_q   <= '0;
            oram_vld_q <= 1'b0;
            oram_add_q <= '0;
            oram_bnk_q <= '0;
            oram_dat_q <= '0;
        end else begin
            base_q     <= base_d;
            lst_seen_q <= lst_seen_d;
            rr_ptr_q   <= rr_ptr_d;
            oram_vld_q <= oram_vld_d;
            oram_add_q <= oram_add_d;
            oram_bnk_q <= oram_bnk_d;
            oram_dat_q <= oram_dat_d;
        end
    end

    assign ORAM_VLD = oram_vld_q;
    assign ORAM_ADD = oram_add_q;
    assign ORAM_BNK = oram_bnk_q;
    assign ORAM_DAT = oram_dat_q;

endmodule

// File: tb/tb_eeg_pea_out_collector.sv
// Testbench for eeg_pea_out_collector: per-PE beat queues drive the streams, a cycle model
// built from the collector's rules predicts grants, ORAM writes, DONE and IS_IDLE.
module tb_eeg_pea_out_collector;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RW = 10;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            CFG_START;
    logic [RW-1:0]   CFG_OUT_BASE;
    logic            IS_IDLE;
    logic            DONE;
    logic [N-1:0]    OUT_VLD;
    logic [N-1:0]    OUT_LST;
    logic [N-1:0]    OUT_RDY;
    logic [N*DW-1:0] OUT_DAT;
    logic [N*AW-1:0] OUT_ADD;
    logic            ORAM_VLD;
    logic            ORAM_RDY;
    logic [RW-1:0]   ORAM_ADD;
    logic [IW-1:0]   ORAM_BNK;
    logic [DW-1:0]   ORAM_DAT;

    eeg_pea_out_collector #(
        .PE_NUM(N), .DATA_OUT_DW(DW), .OMUX_ADD_AW(AW), .ORAM_ADD_AW(RW), .PE_IDX_AW(IW)
    ) dut (
        .clk(clk), .rst(rst), .CFG_START(CFG_START), .CFG_OUT_BASE(CFG_OUT_BASE),
        .IS_IDLE(IS_IDLE), .DONE(DONE), .OUT_VLD(OUT_VLD), .OUT_LST(OUT_LST),
        .OUT_RDY(OUT_RDY), .OUT_DAT(OUT_DAT), .OUT_ADD(OUT_ADD), .ORAM_VLD(ORAM_VLD),
        .ORAM_RDY(ORAM_RDY), .ORAM_ADD(ORAM_ADD), .ORAM_BNK(ORAM_BNK), .ORAM_DAT(ORAM_DAT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] add;
        logic [DW-1:0] dat;
        logic          lst;
    } beat_t;

    typedef struct {
        logic [RW-1:0] add;
        logic [IW-1:0] bnk;
        logic [DW-1:0] dat;
        int            cyc;
    } wr_t;

    beat_t pe_q[N][$];
    wr_t   obs_wr[$];
    int    gnt_log[$];
    int    done_log[$];

    int checks, failures, cyc, vld_pct, exp_g;

    // Reference model: layer phase, per-PE LST flags, round-robin pointer, write stage
    bit            m_run, m_fin, m_sv;
    bit            m_lst[N];
    int            m_rr, m_sb;
    logic [RW-1:0] m_base, m_sa;
    logic [DW-1:0] m_sd;

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_sv = 0; m_rr = 0; m_sb = 0; m_sa = '0; m_sd = '0; m_base = '0;
        for (int i = 0; i < N; i++) m_lst[i] = 0;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) pe_q[i].delete();
    endtask

    task automatic add_beat(input int pe, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
        beat_t b;
        b.add = a; b.dat = d; b.lst = l;
        pe_q[pe].push_back(b);
    endtask

    // Drive one cycle's inputs, then mid-cycle compare every output against the model
    task automatic drive_sample(input bit rdy, input bit start);
        beat_t        b;
        logic [N-1:0] exp_rdy;
        bit           free;
        int           idx;
        wr_t          w;
        for (int i = 0; i < N; i++) begin
            b.add = AW'($urandom); b.dat = DW'($urandom); b.lst = 1'($urandom);
            OUT_VLD[i] = 1'b0;
            if (pe_q[i].size() > 0 && int'($urandom_range(99)) < vld_pct) begin
                b = pe_q[i][0];
                OUT_VLD[i] = 1'b1;
            end
            OUT_DAT[i*DW +: DW] = b.dat;
            OUT_ADD[i*AW +: AW] = b.add;
            OUT_LST[i]          = b.lst;
        end
        ORAM_RDY  = rdy;
        CFG_START = start;
        #5;
        free  = !m_sv || rdy;
        exp_g = -1;
        if (m_run && free) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (exp_g < 0 && OUT_VLD[idx] && !m_lst[idx]) exp_g = idx;
            end
        end
        exp_rdy = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
        checks++;
        if (OUT_RDY !== exp_rdy) begin
            failures++; $display("FAIL out_rdy cyc=%0d got=%h exp=%h", cyc, OUT_RDY, exp_rdy);
        end
        checks++;
        if (IS_IDLE !== (!m_run && !m_fin)) begin
            failures++; $display("FAIL is_idle cyc=%0d got=%b exp=%b", cyc, IS_IDLE, !m_run && !m_fin);
        end
        checks++;
        if (DONE !== m_fin) begin
            failures++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, DONE, m_fin);
        end
        checks++;
        if (ORAM_VLD !== m_sv) begin
            failures++; $display("FAIL oram_vld cyc=%0d got=%b exp=%b", cyc, ORAM_VLD, m_sv);
        end
        if (m_sv) begin
            checks++;
            if (ORAM_ADD !== m_sa || ORAM_BNK !== IW'(m_sb) || ORAM_DAT !== m_sd) begin
                failures++;
                $display("FAIL oram_beat cyc=%0d got add=%h bnk=%0d dat=%h exp add=%h bnk=%0d dat=%h",
                         cyc, ORAM_ADD, ORAM_BNK, ORAM_DAT, m_sa, m_sb, m_sd);
            end
        end
        if (ORAM_VLD === 1'b1 && rdy) begin
            w.add = ORAM_ADD; w.bnk = ORAM_BNK; w.dat = ORAM_DAT; w.cyc = cyc;
            obs_wr.push_back(w);
        end
        if (DONE === 1'b1) done_log.push_back(cyc);
        for (int i = N - 1; i >= 0; i--) if (OUT_RDY[i] === 1'b1) idx = i;
        if (OUT_RDY != '0) gnt_log.push_back(idx);
    endtask

    // Advance the model by the rules for this cycle, then clock
    task automatic advance();
        bit    all_lst;
        bit    free;
        beat_t b;
        all_lst = 1;
        for (int i = 0; i < N; i++) all_lst &= m_lst[i];
        free = !m_sv || ORAM_RDY;
        b = '0;
        if (exp_g >= 0) b = pe_q[exp_g].pop_front();
        if (rst) begin
            model_reset();
        end else begin
            if (m_fin) m_fin = 0;
            else if (!m_run) begin
                if (CFG_START) begin
                    m_run = 1; m_base = CFG_OUT_BASE;
                    for (int i = 0; i < N; i++) m_lst[i] = 0;
                end
            end else if (all_lst && free) begin
                m_run = 0; m_fin = 1;
            end
            if (exp_g >= 0) begin
                m_sv = 1; m_sa = m_base + RW'(b.add); m_sb = exp_g; m_sd = b.dat;
                m_rr = (exp_g + 1) % N;
                if (b.lst) m_lst[exp_g] = 1;
            end else if (ORAM_RDY) begin
                m_sv = 0;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1; drive_sample(1, 0); advance(); rst = 0;
    endtask

    task automatic start_layer(input logic [RW-1:0] base);
        CFG_OUT_BASE = base;
        drive_sample(1, 1); advance();
    endtask

    task automatic finish_layer(input int budget, input int rdy_pct);
        int n0;
        bit r;
        n0 = done_log.size();
        for (int k = 0; k < budget; k++) begin
            r = int'($urandom_range(99)) < rdy_pct;
            drive_sample(r, 0); advance();
            if (done_log.size() > n0) break;
        end
        checks++;
        if (done_log.size() != n0 + 1) begin
            failures++; $display("FAIL layer_done got=%0d pulses exp=1", done_log.size() - n0);
        end
    endtask

    task automatic test_reset();
        clear_q();
        for (int i = 0; i < N; i++) add_beat(i, AW'(i), DW'(i), 1'b1);
        vld_pct = 100;
        drive_sample(1, 1);
        checks++;
        if (ORAM_ADD !== '0 || ORAM_BNK !== '0 || ORAM_DAT !== '0) begin
            failures++; $display("FAIL reset_fields got add=%h bnk=%h dat=%h exp 0", ORAM_ADD, ORAM_BNK, ORAM_DAT);
        end
        advance();
        rst = 0;
        drive_sample(1, 0);
        checks++;
        if (OUT_RDY !== '0) begin
            failures++; $display("FAIL idle_no_ack got=%h exp=0", OUT_RDY);
        end
        advance();
        clear_q();
    endtask

    task automatic test_single_pe();
        logic [DW-1:0] d5[3];
        int w0, n0, n;
        d5[0] = 8'h11; d5[1] = 8'h22; d5[2] = 8'h33;
        clear_q();
        for (int i = 0; i < N; i++)
            if (i != 5) add_beat(i, AW'($urandom), DW'($urandom), 1'b1);
        for (int k = 0; k < 3; k++) add_beat(5, AW'(k), d5[k], k == 2);
        vld_pct = 100;
        w0 = obs_wr.size(); n0 = done_log.size();
        start_layer(10'h100);
        finish_layer(200, 100);
        n = 0;
        for (int k = w0; k < obs_wr.size(); k++) begin
            if (obs_wr[k].bnk == IW'(5)) begin
                if (n < 3) begin
                    checks++;
                    if (obs_wr[k].add !== RW'(32'h100 + n) || obs_wr[k].dat !== d5[n]) begin
                        failures++;
                        $display("FAIL pe5_write%0d got add=%h dat=%h exp add=%h dat=%h",
                                 n, obs_wr[k].add, obs_wr[k].dat, RW'(32'h100 + n), d5[n]);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL pe5_count got=%0d exp=3", n); end
        checks++;
        if (done_log.size() != n0 + 1 || done_log[done_log.size()-1] - obs_wr[obs_wr.size()-1].cyc != 1) begin
            failures++; $display("FAIL done_latency got=%0d exp=1",
                                 done_log[done_log.size()-1] - obs_wr[obs_wr.size()-1].cyc);
        end
        drive_sample(1, 0);
        checks++;
        if (IS_IDLE !== 1'b1) begin failures++; $display("FAIL idle_after got=%b exp=1", IS_IDLE); end
        advance();
    endtask

    task automatic test_rotation();
        int g0, w0;
        do_reset();
        clear_q();
        for (int i = 0; i < N; i++) begin
            add_beat(i, AW'(2*i), DW'($urandom), 1'b0);
            add_beat(i, AW'(2*i+1), DW'($urandom), 1'b1);
        end
        vld_pct = 100;
        g0 = gnt_log.size(); w0 = obs_wr.size();
        start_layer(10'h000);
        finish_layer(200, 100);
        checks++;
        if (gnt_log.size() - g0 != 2*N) begin
            failures++; $display("FAIL rot_grants got=%0d exp=%0d", gnt_log.size() - g0, 2*N);
        end else begin
            for (int k = 0; k < 2*N; k++) begin
                checks++;
                if (gnt_log[g0+k] != k % N) begin
                    failures++; $display("FAIL rot_order%0d got=%0d exp=%0d", k, gnt_log[g0+k], k % N);
                end
            end
        end
        checks++;
        if (obs_wr.size() - w0 != 2*N || obs_wr[obs_wr.size()-1].cyc - obs_wr[w0].cyc != 2*N - 1) begin
            failures++; $display("FAIL rot_throughput got=%0d writes exp=%0d back-to-back", obs_wr.size() - w0, 2*N);
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) add_beat(i, AW'($urandom), DW'($urandom), k == 2);
        vld_pct = 100;
        start_layer(10'h040);
        drive_sample(1, 0); advance();
        drive_sample(1, 0); advance();
        for (int s = 0; s < 4; s++) begin
            drive_sample(0, 0);
            checks++;
            if (OUT_RDY !== '0 || ORAM_VLD !== 1'b1) begin
                failures++; $display("FAIL stall%0d got rdy=%h vld=%b exp rdy=0 vld=1", s, OUT_RDY, ORAM_VLD);
            end
            advance();
        end
        drive_sample(1, 0);
        checks++;
        if ($countones(OUT_RDY) != 1) begin
            failures++; $display("FAIL release_grant got=%h exp one-hot", OUT_RDY);
        end
        advance();
        finish_layer(300, 100);
    endtask

    task automatic test_wrap();
        int w0, n;
        clear_q();
        add_beat(0, 8'h20, 8'hA5, 1'b1);
        for (int i = 1; i < N; i++) add_beat(i, 8'h00, DW'($urandom), 1'b1);
        vld_pct = 100;
        w0 = obs_wr.size();
        start_layer(10'h3F0);
        finish_layer(200, 100);
        n = 0;
        for (int k = w0; k < obs_wr.size(); k++) begin
            if (obs_wr[k].bnk == IW'(0)) begin
                n++;
                checks++;
                if (obs_wr[k].add !== 10'h010) begin
                    failures++; $display("FAIL wrap_addr got=%h exp=010", obs_wr[k].add);
                end
            end
        end
        checks++;
        if (n != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", n); end
    endtask

    task automatic test_lst_block();
        int w0, n;
        clear_q();
        for (int i = 0; i < N; i++) begin
            if (i == 3) begin
                add_beat(3, AW'($urandom), 8'h5A, 1'b1);
                add_beat(3, AW'($urandom), 8'hEE, 1'b0);
            end else begin
                add_beat(i, AW'($urandom), DW'($urandom), 1'b0);
                add_beat(i, AW'($urandom), DW'($urandom), 1'b1);
            end
        end
        vld_pct = 100;
        w0 = obs_wr.size();
        start_layer(10'h123);
        finish_layer(400, 70);
        n = 0;
        for (int k = w0; k < obs_wr.size(); k++) if (obs_wr[k].bnk == IW'(3)) n++;
        checks++;
        if (n != 1) begin failures++; $display("FAIL pe3_after_lst got=%0d writes exp=1", n); end
        drive_sample(1, 0); advance();
        clear_q();
    endtask

    task automatic test_reset_mid_run();
        int d0;
        clear_q();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) add_beat(i, AW'($urandom), DW'($urandom), k == 3);
        vld_pct = 100;
        start_layer(10'h200);
        drive_sample(1, 0); advance();
        drive_sample(0, 0); advance();
        d0 = done_log.size();
        rst = 1; drive_sample(0, 0); advance(); rst = 0;
        drive_sample(1, 0);
        checks++;
        if (ORAM_VLD !== 1'b0 || IS_IDLE !== 1'b1 || DONE !== 1'b0) begin
            failures++; $display("FAIL mid_reset got vld=%b idle=%b done=%b exp 0 1 0", ORAM_VLD, IS_IDLE, DONE);
        end
        advance();
        for (int k = 0; k < 3; k++) begin drive_sample(1, 0); advance(); end
        checks++;
        if (done_log.size() != d0) begin failures++; $display("FAIL mid_reset_done got=%0d exp=0", done_log.size() - d0); end
        clear_q();
        for (int i = 0; i < N; i++) add_beat(i, AW'($urandom), DW'($urandom), 1'b1);
        start_layer(10'h080);
        finish_layer(200, 100);
    endtask

    task automatic test_random();
        int w0, total, nb;
        for (int l = 0; l < 4; l++) begin
            clear_q();
            total = 0;
            for (int i = 0; i < N; i++) begin
                nb = int'($urandom_range(4, 1));
                for (int k = 0; k < nb; k++) add_beat(i, AW'($urandom), DW'($urandom), k == nb - 1);
                total += nb;
            end
            vld_pct = 60;
            w0 = obs_wr.size();
            start_layer(RW'($urandom));
            finish_layer(2000, 60);
            checks++;
            if (obs_wr.size() - w0 != total) begin
                failures++; $display("FAIL rand_layer%0d writes got=%0d exp=%0d", l, obs_wr.size() - w0, total);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; vld_pct = 100; exp_g = -1;
        rst = 1; CFG_START = 0; CFG_OUT_BASE = '0;
        OUT_VLD = '0; OUT_LST = '0; OUT_DAT = '0; OUT_ADD = '0; ORAM_RDY = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_pe();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_lst_block();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
